// File: rtl/fifo_wr_arb_if.sv
// Requester, memory-port and consumer signals of the FIFO write arbiter.
// The master side drives requests and pops.
// The slave side (the arbiter) drives grants, memory controls and status.
interface fifo_wr_arb_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4,
  parameter int NREQ     = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]          req_valid;
  logic [NREQ*DATASIZE-1:0] req_data;
  logic [NREQ-1:0]          req_ready;
  logic [IDW-1:0]           grant_id;
  logic                     wclken;
  logic [ADDRSIZE-1:0]      waddr;
  logic [DATASIZE-1:0]      wdata;
  logic                     wfull;
  logic                     rinc;
  logic [ADDRSIZE-1:0]      raddr;
  logic                     rempty;
  logic [ADDRSIZE:0]        count;

  modport master (
    output req_valid, req_data, rinc,
    input  req_ready, grant_id, wclken, waddr, wdata, wfull, raddr, rempty, count
  );

  modport slave (
    input  req_valid, req_data, rinc,
    output req_ready, grant_id, wclken, waddr, wdata, wfull, raddr, rempty, count
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// Purpose: round-robin share of the fifomem write port, plus the FIFO pointers and status.
// Latency: the grant is in the same cycle as valid, and the write lands at the accepting edge.
// Backpressure: when full, or while in reset, no requester is granted; pops still proceed.
module fifo_wr_arb #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4,
  parameter int NREQ     = 4
) (
  input logic          wclk,
  input logic          wrst_n,
  fifo_wr_arb_if.slave bus
);
  localparam int IDW = $clog2(NREQ);
  localparam int PW  = ADDRSIZE + 1;
  localparam logic [PW-1:0]  DEPTH    = PW'(2 ** ADDRSIZE);
  localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

  logic [PW-1:0]  wptr_q, wptr_d;
  logic [PW-1:0]  rptr_q, rptr_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] gid_q, gid_d;

  logic [PW-1:0]  count;
  logic           empty;
  logic           full;
  logic           win_vld;
  logic [IDW-1:0] win_idx;
  logic           push;
  logic           pop;

  // The extra pointer bit separates full from empty, so the modular difference is the occupancy.
  assign count = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (count == DEPTH);

  // Scan the requesters, starting one past the last winner and wrapping around.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_vld && bus.req_valid[IDW'((int'(last_q) + k) % NREQ)]) begin
        win_vld = 1'b1;
        win_idx = IDW'((int'(last_q) + k) % NREQ);
      end
    end
  end

  // Gate grants with reset so that a transfer in the reset cycle is visibly refused.
  assign push = wrst_n & ~full & win_vld;
  assign pop  = bus.rinc & ~empty;

  // One-hot ready at the winner, and steer the winner's word onto the write data.
  always_comb begin
    bus.req_ready = '0;
    bus.wdata     = '0;
    if (push) begin
      bus.req_ready[win_idx] = 1'b1;
      bus.wdata              = bus.req_data[win_idx*DATASIZE +: DATASIZE];
    end
  end

  // Next state: advance the pointers on a transfer, and remember the winner.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    last_d = last_q;
    gid_d  = gid_q;
    if (push) begin
      wptr_d = wptr_q + PW'(1);
      last_d = win_idx;
      gid_d  = win_idx;
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
  end

  // State registers; reset makes requester 0 first in line.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      last_q <= LAST_RST;
      gid_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      last_q <= last_d;
      gid_q  <= gid_d;
    end
  end

  assign bus.wclken   = push;
  assign bus.waddr    = wptr_q[ADDRSIZE-1:0];
  assign bus.raddr    = rptr_q[ADDRSIZE-1:0];
  assign bus.wfull    = full;
  assign bus.rempty   = empty;
  assign bus.count    = count;
  assign bus.grant_id = gid_q;
endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb. It uses a local fifomem stand-in, a reference
// pointer/arbiter model, and a data scoreboard, with table vectors and corner-case sequences.
module tb_fifo_wr_arb;
  logic wclk = 1'b0;
  logic wrst_n;
  always #5 wclk = ~wclk;

  fifo_wr_arb_if #(.DATASIZE(8), .ADDRSIZE(4), .NREQ(4)) bus ();
  fifo_wr_arb #(.DATASIZE(8), .ADDRSIZE(4), .NREQ(4)) dut (
    .wclk  (wclk),
    .wrst_n(wrst_n),
    .bus   (bus)
  );

  logic [7:0] mem [16];
  logic [7:0] wd  [4];
  logic [7:0] rdata;
  assign bus.req_data = {wd[3], wd[2], wd[1], wd[0]};
  assign rdata        = mem[bus.raddr];

  // fifomem write port stand-in
  always @(posedge wclk) begin
    if (bus.wclken && !bus.wfull) mem[bus.waddr] <= bus.wdata;
  end

  int n_chk;
  int n_fail;
  int m_wptr, m_rptr, m_last, m_gid;
  logic [7:0] sbq [$];

  typedef struct {
    logic [3:0] valid;
    logic       rinc;
    logic [3:0] exp_ready;
    logic [4:0] exp_count;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (v[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_clear();
    m_wptr = 0;
    m_rptr = 0;
    m_last = 3;
    m_gid  = 0;
    sbq.delete();
  endtask

  // One clock cycle: drive at the falling edge, check the combinational outputs,
  // then check the registered state after the rising edge.
  task automatic drive_cycle(input logic [3:0] v, input logic r, output logic [3:0] rdy_seen);
    int w;
    int cnt;
    logic do_push;
    logic do_pop;
    logic [3:0] exp_rdy;
    logic [7:0] exp_word;
    @(negedge wclk);
    bus.req_valid = v;
    bus.rinc      = r;
    #1;
    cnt     = (m_wptr - m_rptr) & 31;
    w       = (cnt == 16) ? -1 : rr_pick(v, m_last);
    do_push = (w >= 0);
    do_pop  = r && (cnt != 0);
    exp_rdy = do_push ? 4'(4'b0001 << w) : 4'b0000;
    rdy_seen = bus.req_ready;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("wclken", 32'(bus.wclken), 32'(do_push));
    chk("count", 32'(bus.count), 32'(cnt));
    chk("rempty", 32'(bus.rempty), 32'(cnt == 0));
    chk("wfull", 32'(bus.wfull), 32'(cnt == 16));
    chk("waddr", 32'(bus.waddr), 32'(m_wptr & 15));
    chk("raddr", 32'(bus.raddr), 32'(m_rptr & 15));
    if (do_push) begin
      exp_word = wd[w];
      chk("wdata", 32'(bus.wdata), 32'(exp_word));
      sbq.push_back(exp_word);
    end
    if (do_pop) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard: pop with no expected word, got 0x%0h", rdata);
      end else begin
        chk("rdata", 32'(rdata), 32'(sbq.pop_front()));
      end
    end
    @(posedge wclk);
    #1;
    if (do_push) begin
      m_wptr = (m_wptr + 1) & 31;
      m_last = w;
      m_gid  = w;
      wd[w]  = wd[w] + 8'h04;
    end
    if (do_pop) m_rptr = (m_rptr + 1) & 31;
    chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
  endtask

  task automatic apply_reset();
    @(negedge wclk);
    bus.req_valid = 4'b0000;
    bus.rinc      = 1'b0;
    wrst_n        = 1'b0;
    #1;
    model_clear();
    chk("rst_rempty", 32'(bus.rempty), 32'd1);
    chk("rst_wfull", 32'(bus.wfull), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_wclken", 32'(bus.wclken), 32'd0);
    chk("rst_waddr", 32'(bus.waddr), 32'd0);
    chk("rst_raddr", 32'(bus.raddr), 32'd0);
    chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] seen;
    logic [7:0] w0;
    tbl[0]  = '{4'b0100, 1'b0, 4'b0100, 5'd1};
    tbl[1]  = '{4'b0000, 1'b0, 4'b0000, 5'd1};
    tbl[2]  = '{4'b1111, 1'b0, 4'b1000, 5'd2};
    tbl[3]  = '{4'b0011, 1'b1, 4'b0001, 5'd2};
    tbl[4]  = '{4'b0011, 1'b0, 4'b0010, 5'd3};
    tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 5'd2};
    tbl[6]  = '{4'b0101, 1'b1, 4'b0100, 5'd2};
    tbl[7]  = '{4'b0001, 1'b0, 4'b0001, 5'd3};
    tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 5'd2};
    tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 5'd1};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 5'd0};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 5'd0};
    tbl[12] = '{4'b1000, 1'b1, 4'b1000, 5'd1};
    tbl[13] = '{4'b0000, 1'b1, 4'b0000, 5'd0};

    n_chk         = 0;
    n_fail        = 0;
    wrst_n        = 1'b0;
    bus.req_valid = 4'b0000;
    bus.rinc      = 1'b0;
    wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'hA5; wd[3] = 8'h44;
    model_clear();

    // Table vectors from reset: a single push, rotation, push+pop, and a pop while empty.
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      drive_cycle(tbl[i].valid, tbl[i].rinc, seen);
      chk("tbl_ready", 32'(seen), 32'(tbl[i].exp_ready));
      chk("tbl_count", 32'(bus.count), 32'(tbl[i].exp_count));
      if (i == 0) begin
        chk("first_rempty", 32'(bus.rempty), 32'd0);
        chk("first_raddr", 32'(bus.raddr), 32'd0);
        chk("first_rdata", 32'(rdata), 32'hA5);
      end
    end

    // All requesters valid with no pops: strict rotation until full, then no grants.
    apply_reset();
    for (int i = 0; i < 4; i++) wd[i] = 8'(8'h10 + i);
    for (int i = 0; i < 20; i++) begin
      drive_cycle(4'b1111, 1'b0, seen);
      if (i < 16) chk("rr_order", 32'(bus.grant_id), 32'(i % 4));
      else        chk("full_ready", 32'(seen), 32'd0);
    end
    chk("full_wfull", 32'(bus.wfull), 32'd1);
    chk("full_count", 32'(bus.count), 32'd16);

    // Full with a pop: no write on that edge, then the grant resumes at requester 0.
    drive_cycle(4'b1111, 1'b1, seen);
    chk("fullpop_ready", 32'(seen), 32'd0);
    chk("fullpop_count", 32'(bus.count), 32'd15);
    drive_cycle(4'b1111, 1'b0, seen);
    chk("resume_ready", 32'(seen), 32'b0001);
    for (int i = 0; i < 16; i++) drive_cycle(4'b0000, 1'b1, seen);
    chk("drain_rempty", 32'(bus.rempty), 32'd1);

    // Half full, with a steady push and pop; both pointers wrap past 31.
    for (int i = 0; i < 8; i++) drive_cycle(4'b1111, 1'b0, seen);
    for (int i = 0; i < 20; i++) begin
      drive_cycle(4'b1111, 1'b1, seen);
      chk("steady_count", 32'(bus.count), 32'd8);
    end
    chk("wrap_waddr", 32'(bus.waddr), 32'd13);
    chk("wrap_raddr", 32'(bus.raddr), 32'd5);
    for (int i = 0; i < 8; i++) drive_cycle(4'b0000, 1'b1, seen);

    // Pops requested while empty are ignored.
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(4'b0000, 1'b1, seen);
      chk("empty_raddr", 32'(bus.raddr), 32'd0);
      chk("empty_rempty", 32'(bus.rempty), 32'd1);
      chk("empty_count", 32'(bus.count), 32'd0);
    end

    // Reset mid-stream at count 5 clears the status at once; a fresh push lands at address 0.
    for (int i = 0; i < 5; i++) drive_cycle(4'b0001, 1'b0, seen);
    chk("pre_rst_count", 32'(bus.count), 32'd5);
    @(negedge wclk);
    bus.req_valid = 4'b0010;
    #1;
    wrst_n = 1'b0;
    #1;
    chk("midrst_rempty", 32'(bus.rempty), 32'd1);
    chk("midrst_count", 32'(bus.count), 32'd0);
    chk("midrst_ready", 32'(bus.req_ready), 32'd0);
    chk("midrst_wclken", 32'(bus.wclken), 32'd0);
    @(negedge wclk);
    wrst_n        = 1'b1;
    bus.req_valid = 4'b0000;
    model_clear();
    #1;
    chk("post_rst_waddr", 32'(bus.waddr), 32'd0);
    w0 = wd[1];
    drive_cycle(4'b0010, 1'b0, seen);
    chk("post_rst_ready", 32'(seen), 32'b0010);
    chk("post_rst_mem0", 32'(mem[0]), 32'(w0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Single-clock write arbiter and pointer controller for the `fifomem` dual-port RAM. It shares the memory's single write port among NREQ valid/ready requesters using round-robin arbitration. It owns the binary write and read pointers and produces `wfull`, `rempty` and occupancy. It sits between the requester ports and `fifomem`, driving its `wclken`, `waddr`, `wdata`, `wfull` and `raddr` inputs directly.

## Interface
- DATASIZE, 8, width of one FIFO word
- ADDRSIZE, 4, memory address width; DEPTH = 2**ADDRSIZE
- NREQ, 4, number of write requesters (>= 2)

- wclk  in  1  clock, shared by write and read sides
- wrst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  requester i has a word
- req_data  in  NREQ*DATASIZE  requester i word at [i*DATASIZE +: DATASIZE]
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- grant_id  out  $clog2(NREQ)  index of last accepted requester (registered)
- wclken  out  1  write enable to fifomem
- waddr  out  ADDRSIZE  write address to fifomem
- wdata  out  DATASIZE  write data to fifomem (selected requester word)
- wfull  out  1  FIFO full; also to fifomem write guard
- rinc  in  1  pop request from consumer
- raddr  out  ADDRSIZE  read address to fifomem; rdata = mem[raddr]
- rempty  out  1  FIFO empty
- count  out  ADDRSIZE+1  occupancy, 0..DEPTH

## Operation
- State: wptr, rptr (ADDRSIZE+1-bit binary, wrap modulo 2**(ADDRSIZE+1)); last (index of last winner).
- waddr = wptr[ADDRSIZE-1:0]; raddr = rptr[ADDRSIZE-1:0].
- count = wptr - rptr (modular); rempty = (wptr == rptr); wfull = (count == DEPTH). All are combinational from registers only.
- Arbitration (combinational): when wfull=0, scan req_valid starting at (last+1) mod NREQ and wrapping. The first asserted index wins, req_ready gets a one-hot at the winner, and wclken=1. wdata = req_data of the winner.
- No valid, or wfull=1: req_ready=0, wclken=0, wdata=0.
- On a transfer edge: wptr += 1, last <= winner, grant_id <= winner. Otherwise last and grant_id hold.
- Pop: if rinc=1 and rempty=0, rptr += 1 at the edge. rinc while empty is ignored, with no pointer change and no error.
- Push and pop in the same cycle (not full, not empty): both pointers advance and count is unchanged.
- Full with rinc=1: the pop proceeds. The push is blocked that cycle because the full decision uses the pre-edge count, and requesters see ready the next cycle.
- Empty with a push: the pop is ignored that cycle, even if rinc=1.
- req_ready depends combinationally on req_valid. Requesters hold req_valid and req_data stable until accepted and must not make valid depend on ready.

## Timing
- Reset (wrst_n low, async): wptr=rptr=0, last=NREQ-1 (requester 0 has first priority), grant_id=0. Outputs: rempty=1, wfull=0, count=0, req_ready=0, wclken=0, waddr=raddr=0.
- Reset asserted mid-operation clears the pointers immediately and the FIFO reads as empty. Memory contents are not cleared. Transfers in the reset cycle are lost.
- Grant latency: 0 cycles (ready in the same cycle as valid, when not full). The memory write occurs at the accepting edge.
- Write-to-read latency: a word pushed at edge k makes rempty fall after edge k. The word is on fifomem rdata in cycle k+1 (async read).
- Throughput: one push and one pop per cycle maximum.
- Fairness: with all NREQ valid continuously, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 transfers.

## Test plan
- Reset, then requester 2 pushes 0xA5 with rinc=0. Required: req_ready=4'b0100 in the same cycle, count=1 and rempty=0 after the edge, and rdata=0xA5 at raddr=0 next cycle.
- All 4 requesters valid continuously from reset, with words 0x10+i, and no pops. Required: grant order 0,1,2,3,0,1,..., wfull=1 after 16 pushes, req_ready=0 thereafter, and count=16.
- Full FIFO with rinc=1 and req_valid=4'b1111. Required: on the first edge count=15 with no write. On the next cycle a grant resumes from last+1, and the data order is preserved.
- Half-full FIFO (count=8) with a simultaneous push and pop for 20 cycles. Required: count stays at 8, and wptr/rptr wrap past 31→0 with correct data returned.
- Empty FIFO with rinc=1 pulsed for 3 cycles. Required: rptr stays at 0, rempty stays 1, and count stays 0.
- Assert wrst_n=0 mid-stream at count=5. Required: rempty=1, count=0, req_ready=0 and wclken=0 immediately (before any edge), then a fresh push after release lands at waddr=0.
